// File: rtl/mem_access_unit.sv
// Load/store unit between the execute stage and a word-wide data RAM.
// Sub-word stores use read-modify-write; every response is a single-cycle pulse.
module mem_access_unit #(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [2:0]        req_funct3_i,
    input  logic [31:0]       req_addr_i,
    input  logic [31:0]       req_wdata_i,
    output logic              resp_valid_o,
    output logic [31:0]       resp_rdata_o,
    output logic              resp_err_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [31:0]       ram_wdata_o,
    output logic              ram_we_o,
    input  logic [31:0]       ram_rdata_i
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ACCESS = 3'd1,
        WRITE  = 3'd2,
        RESP   = 3'd3,
        ERR    = 3'd4
    } state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Any of: illegal funct3 for the direction, misalignment, or address beyond the RAM.
    function automatic logic req_illegal(input logic we, input logic [2:0] f3,
                                         input logic [31:0] addr);
        logic bad_f3;
        logic misal;
        logic oor;
        case (f3)
            F3_B, F3_H, F3_W: bad_f3 = 1'b0;
            F3_BU, F3_HU:     bad_f3 = we;
            default:          bad_f3 = 1'b1;
        endcase
        case (f3[1:0])
            2'b01:   misal = addr[0];
            2'b10:   misal = |addr[1:0];
            default: misal = 1'b0;
        endcase
        oor = (addr >> ADDR_W) != 32'd0;
        return bad_f3 | misal | oor;
    endfunction

    function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] lo,
                                                 input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{lo, 3'b000} +: 8];
        h = lo[1] ? word[31:16] : word[15:0];
        case (f3)
            F3_B:    r = {{24{b[7]}}, b};
            F3_H:    r = {{16{h[15]}}, h};
            F3_W:    r = word;
            F3_BU:   r = {24'd0, b};
            F3_HU:   r = {16'd0, h};
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] store_merge(input logic [2:0] f3, input logic [1:0] lo,
                                                input logic [31:0] old_word,
                                                input logic [31:0] wd);
        logic [31:0] m;
        m = old_word;
        case (f3)
            F3_B: m[{lo, 3'b000} +: 8] = wd[7:0];
            F3_H: begin
                if (lo[1]) begin
                    m[31:16] = wd[15:0];
                end else begin
                    m[15:0] = wd[15:0];
                end
            end
            default: m = wd;
        endcase
        return m;
    endfunction

    state_t              state_q, state_d;
    logic                we_q, we_d;
    logic [2:0]          f3_q, f3_d;
    logic [31:0]         addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic                resp_valid_q, resp_valid_d;
    logic [31:0]         resp_rdata_q, resp_rdata_d;
    logic                resp_err_q, resp_err_d;
    logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
    logic [31:0]         ram_wdata_q, ram_wdata_d;
    logic                ram_we_q, ram_we_d;

    // Next-state and registered-output computation; all RAM/response outputs are set one edge early.
    always_comb begin
        state_d      = state_q;
        we_d         = we_q;
        f3_d         = f3_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = 1'b0;
        ram_addr_d   = ram_addr_q;
        ram_wdata_d  = ram_wdata_q;
        ram_we_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    we_d    = req_we_i;
                    f3_d    = req_funct3_i;
                    addr_d  = req_addr_i;
                    wdata_d = req_wdata_i;
                    if (req_illegal(req_we_i, req_funct3_i, req_addr_i)) begin
                        state_d      = ERR;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                        resp_rdata_d = 32'd0;
                    end else begin
                        state_d    = ACCESS;
                        ram_addr_d = req_addr_i[ADDR_W-1:0];
                        if (req_we_i && (req_funct3_i == F3_W)) begin
                            ram_we_d    = 1'b1;
                            ram_wdata_d = req_wdata_i;
                        end else begin
                            ram_we_d = 1'b0;
                        end
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            ACCESS: begin
                if (!we_q) begin
                    resp_rdata_d = load_extract(f3_q, addr_q[1:0], ram_rdata_i);
                    resp_valid_d = 1'b1;
                    state_d      = RESP;
                end else if (f3_q == F3_W) begin
                    resp_rdata_d = 32'd0;
                    resp_valid_d = 1'b1;
                    state_d      = RESP;
                end else begin
                    ram_wdata_d = store_merge(f3_q, addr_q[1:0], ram_rdata_i, wdata_q);
                    ram_we_d    = 1'b1;
                    state_d     = WRITE;
                end
            end
            WRITE: begin
                resp_rdata_d = 32'd0;
                resp_valid_d = 1'b1;
                state_d      = RESP;
            end
            RESP:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            we_q         <= 1'b0;
            f3_q         <= 3'd0;
            addr_q       <= 32'd0;
            wdata_q      <= 32'd0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'd0;
            resp_err_q   <= 1'b0;
            ram_addr_q   <= '0;
            ram_wdata_q  <= 32'd0;
            ram_we_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            we_q         <= we_d;
            f3_q         <= f3_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            ram_addr_q   <= ram_addr_d;
            ram_wdata_q  <= ram_wdata_d;
            ram_we_q     <= ram_we_d;
        end
    end

    assign req_ready_o  = (state_q == IDLE);
    assign resp_valid_o = resp_valid_q;
    assign resp_rdata_o = resp_rdata_q;
    assign resp_err_o   = resp_err_q;
    assign ram_addr_o   = ram_addr_q;
    assign ram_wdata_o  = ram_wdata_q;
    assign ram_we_o     = ram_we_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed, table-driven bench for mem_access_unit with a behavioural 64 B RAM.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [5:0]  ram_addr;
    logic [31:0] ram_wdata;
    logic        ram_we;
    logic [31:0] ram_rdata;

    logic [31:0] mem [16];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign ram_rdata = mem[ram_addr[5:2]];

    always @(posedge clk) begin
        if (ram_we) mem[ram_addr[5:2]] <= ram_wdata;
    end

    mem_access_unit #(.ADDR_W(6)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_we_i     (req_we),
        .req_funct3_i (req_funct3),
        .req_addr_i   (req_addr),
        .req_wdata_i  (req_wdata),
        .resp_valid_o (resp_valid),
        .resp_rdata_o (resp_rdata),
        .resp_err_o   (resp_err),
        .ram_addr_o   (ram_addr),
        .ram_wdata_o  (ram_wdata),
        .ram_we_o     (ram_we),
        .ram_rdata_i  (ram_rdata)
    );

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_err;
        logic [31:0] exp_rdata;
        int          exp_lat;
        int          exp_wecnt;
        logic [31:0] exp_wd;
    } vec_t;

    vec_t vecs[22];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Issue one request, then watch the following cycles for RAM writes and the response.
    task automatic run_vec(input vec_t v, input string name);
        int          lat;
        int          wecnt;
        int          wk;
        logic [31:0] wd;
        logic        got;
        logic        err;
        logic [31:0] rd;
        lat = 0; wecnt = 0; wk = 0; wd = 32'd0; got = 1'b0; err = 1'b0; rd = 32'd0;
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = v.we;
        req_funct3 = v.f3;
        req_addr   = v.addr;
        req_wdata  = v.wdata;
        chk({name, " ready"}, {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int k = 1; k <= 8 && !got; k++) begin
            @(negedge clk);
            if (ram_we) begin
                wecnt++;
                wd = ram_wdata;
                wk = k;
            end
            if (resp_valid) begin
                got = 1'b1;
                lat = k;
                err = resp_err;
                rd  = resp_rdata;
            end
        end
        chk({name, " latency"}, lat, v.exp_lat);
        chk({name, " err"}, {31'd0, err}, {31'd0, v.exp_err});
        chk({name, " rdata"}, rd, v.exp_rdata);
        chk({name, " we_count"}, wecnt, v.exp_wecnt);
        if (v.exp_wecnt != 0) begin
            chk({name, " wdata"}, wd, v.exp_wd);
            chk({name, " we_cycle"}, wk, v.exp_lat - 1);
        end
        @(negedge clk);
        chk({name, " pulse_end"}, {31'd0, resp_valid}, 32'd0);
    endtask

    initial begin
        vec_t        tmp;
        int          nacc;
        int          nresp;
        int          acc_cyc[2];
        int          resp_cyc[2];
        logic [31:0] resp_dat[2];
        int          we_seen;

        //          we    f3      addr    wdata          err   rdata         lat we wd
        vecs[0]  = '{1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 1'b0, 32'h00000000, 2, 1, 32'hDEADBEEF};
        vecs[1]  = '{1'b0, 3'b010, 32'h10, 32'h0,        1'b0, 32'hDEADBEEF, 2, 0, 32'h0};
        vecs[2]  = '{1'b1, 3'b010, 32'h10, 32'h11223344, 1'b0, 32'h00000000, 2, 1, 32'h11223344};
        vecs[3]  = '{1'b1, 3'b000, 32'h13, 32'h000000AA, 1'b0, 32'h00000000, 3, 1, 32'hAA223344};
        vecs[4]  = '{1'b0, 3'b100, 32'h13, 32'h0,        1'b0, 32'h000000AA, 2, 0, 32'h0};
        vecs[5]  = '{1'b0, 3'b000, 32'h13, 32'h0,        1'b0, 32'hFFFFFFAA, 2, 0, 32'h0};
        vecs[6]  = '{1'b1, 3'b010, 32'h10, 32'h11223344, 1'b0, 32'h00000000, 2, 1, 32'h11223344};
        vecs[7]  = '{1'b1, 3'b001, 32'h12, 32'h00008001, 1'b0, 32'h00000000, 3, 1, 32'h80013344};
        vecs[8]  = '{1'b0, 3'b001, 32'h12, 32'h0,        1'b0, 32'hFFFF8001, 2, 0, 32'h0};
        vecs[9]  = '{1'b0, 3'b101, 32'h12, 32'h0,        1'b0, 32'h00008001, 2, 0, 32'h0};
        vecs[10] = '{1'b0, 3'b001, 32'h10, 32'h0,        1'b0, 32'h00003344, 2, 0, 32'h0};
        vecs[11] = '{1'b0, 3'b000, 32'h10, 32'h0,        1'b0, 32'h00000044, 2, 0, 32'h0};
        vecs[12] = '{1'b0, 3'b010, 32'h11, 32'h0,        1'b1, 32'h00000000, 1, 0, 32'h0};
        vecs[13] = '{1'b0, 3'b001, 32'h01, 32'h0,        1'b1, 32'h00000000, 1, 0, 32'h0};
        vecs[14] = '{1'b1, 3'b010, 32'h40, 32'hDEADBEEF, 1'b1, 32'h00000000, 1, 0, 32'h0};
        vecs[15] = '{1'b0, 3'b011, 32'h00, 32'h0,        1'b1, 32'h00000000, 1, 0, 32'h0};
        vecs[16] = '{1'b1, 3'b100, 32'h10, 32'h000000FF, 1'b1, 32'h00000000, 1, 0, 32'h0};
        vecs[17] = '{1'b1, 3'b010, 32'h04, 32'hCAFEF00D, 1'b0, 32'h00000000, 2, 1, 32'hCAFEF00D};
        vecs[18] = '{1'b1, 3'b000, 32'h05, 32'h12345678, 1'b0, 32'h00000000, 3, 1, 32'hCAFE780D};
        vecs[19] = '{1'b0, 3'b010, 32'h04, 32'h0,        1'b0, 32'hCAFE780D, 2, 0, 32'h0};
        vecs[20] = '{1'b1, 3'b010, 32'h00, 32'h0BADF00D, 1'b0, 32'h00000000, 2, 1, 32'h0BADF00D};
        vecs[21] = '{1'b0, 3'b101, 32'h06, 32'h0,        1'b0, 32'h0000CAFE, 2, 0, 32'h0};

        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
        req_addr = 32'd0; req_wdata = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst resp_err",   {31'd0, resp_err},   32'd0);
        chk("rst resp_rdata", resp_rdata, 32'd0);
        chk("rst ram_we",     {31'd0, ram_we},     32'd0);
        chk("rst ram_addr",   {26'd0, ram_addr},   32'd0);
        chk("rst ram_wdata",  ram_wdata,  32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst req_ready",  {31'd0, req_ready},  32'd1);

        for (int i = 0; i < 22; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset during the ACCESS cycle of a sub-word store must not disturb the RAM.
        tmp = '{1'b1, 3'b010, 32'h08, 32'h55667788, 1'b0, 32'h0, 2, 1, 32'h55667788};
        run_vec(tmp, "abort_prep");
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000;
        req_addr = 32'h08; req_wdata = 32'h000000FF;
        @(posedge clk);
        #1 req_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("abort ram_we",     {31'd0, ram_we},     32'd0);
        chk("abort resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("abort resp_err",   {31'd0, resp_err},   32'd0);
        chk("abort resp_rdata", resp_rdata, 32'd0);
        chk("abort ram_addr",   {26'd0, ram_addr},   32'd0);
        chk("abort ram_wdata",  ram_wdata,  32'd0);
        we_seen = 0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (ram_we) we_seen++;
        end
        chk("abort no_we_after", we_seen, 0);
        chk("abort ready_after", {31'd0, req_ready}, 32'd1);
        tmp = '{1'b0, 3'b010, 32'h08, 32'h0, 1'b0, 32'h55667788, 2, 0, 32'h0};
        run_vec(tmp, "abort_reread");

        // Back-to-back loads with req_valid held high.
        nacc = 0; nresp = 0; we_seen = 0;
        acc_cyc = '{0, 0}; resp_cyc = '{0, 0}; resp_dat = '{32'd0, 32'd0};
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h00;
        for (int c = 0; c < 12; c++) begin
            if (c != 0) @(negedge clk);
            if (ram_we) we_seen++;
            if (resp_valid) begin
                if (nresp < 2) begin
                    resp_cyc[nresp] = c;
                    resp_dat[nresp] = resp_rdata;
                end
                nresp++;
            end
            if (nacc == 1) req_addr = 32'h04;
            if (nacc >= 2) req_valid = 1'b0;
            if (req_valid && req_ready) begin
                if (nacc < 2) acc_cyc[nacc] = c;
                nacc++;
            end
        end
        req_valid = 1'b0;
        chk("b2b accepts",   nacc, 2);
        chk("b2b responses", nresp, 2);
        chk("b2b first_resp_cycle", resp_cyc[0], acc_cyc[0] + 2);
        chk("b2b second_accept",    acc_cyc[1], resp_cyc[0] + 1);
        chk("b2b second_resp_cycle", resp_cyc[1], acc_cyc[1] + 2);
        chk("b2b rdata0", resp_dat[0], 32'h0BADF00D);
        chk("b2b rdata1", resp_dat[1], 32'hCAFE780D);
        chk("b2b no_we", we_seen, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
